// File: rtl/gas_safety_controller.sv
// -----------------------------------------------------------------------------
// gas_safety_controller
//
// Purpose:
//    Sequencing controller for the home gas-safety path. Filters the 3-bit
//    sensor gas level with consecutive-cycle confirmation and drives the
//    ventilation fan, gas supply valve, buzzer and warning LED through a
//    four-state machine (IDLE / WARN / ALARM / VENT). It also keeps a
//    saturating count of ALARM entries.
//
// Parameters:
//    WARN_LVL     gas_lvl threshold (inclusive) for the warning condition
//    ALARM_LVL    gas_lvl threshold (inclusive) for the alarm condition
//    CONFIRM_CYC  consecutive cycles a condition must hold before acting
//    VENT_CYC     ventilation hold time in cycles
//
// Ports:
//    clk          system clock, rising edge
//    arst_n       asynchronous active-low reset
//    gas_lvl      sensor gas level (synchronous to clk)
//    ack          user acknowledge, level-sampled
//    fan_on       ventilation fan enable
//    valve_close  close gas supply valve
//    buzzer       audible alarm
//    led_warn     warning indicator
//    state        current state: 0 IDLE, 1 WARN, 2 ALARM, 3 VENT
//    alarm_cnt    ALARM entries since reset, saturating at 255
//
// Build option:
//    GAS_CTRL_AUTOCLEAR_EN  when defined, ALARM also exits to VENT once LO is
//                           confirmed, without an acknowledge.
// -----------------------------------------------------------------------------
module gas_safety_controller #(
   parameter logic [2:0] WARN_LVL    = 3'd2,
   parameter logic [2:0] ALARM_LVL   = 3'd5,
   parameter int         CONFIRM_CYC = 4,
   parameter int         VENT_CYC    = 16
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic [2:0] gas_lvl,
   input  logic       ack,
   output logic       fan_on,
   output logic       valve_close,
   output logic       buzzer,
   output logic       led_warn,
   output logic [1:0] state,
   output logic [7:0] alarm_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WARN  = 2'd1,
      ALARM = 2'd2,
      VENT  = 2'd3
   } state_e;

   localparam int CW = 4;
   localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM_CYC);
   localparam logic [CW-1:0] CONF_PRE = CW'(CONFIRM_CYC - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] hi_cnt_q, hi_cnt_d;
   logic [CW-1:0] mid_cnt_q, mid_cnt_d;
   logic [CW-1:0] lo_cnt_q, lo_cnt_d;
   logic [7:0]    vent_q, vent_d;
   logic [7:0]    alarm_cnt_q, alarm_cnt_d;
   logic          fan_q, fan_d;
   logic          valve_q, valve_d;
   logic          buzzer_q, buzzer_d;
   logic          led_q, led_d;

   logic hi, mid, lo;
   logic hi_conf, mid_conf, lo_conf;
   logic trans;

   assign hi  = (gas_lvl >= ALARM_LVL);
   assign mid = (gas_lvl >= WARN_LVL);
   assign lo  = ~mid;

   // Confirmed on the edge where the counter would reach CONFIRM_CYC; a
   // counter already saturated keeps the condition confirmed.
   assign hi_conf  = hi  && (hi_cnt_q  >= CONF_PRE);
   assign mid_conf = mid && (mid_cnt_q >= CONF_PRE);
   assign lo_conf  = lo  && (lo_cnt_q  >= CONF_PRE);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c >= CONF_MAX) ? CONF_MAX : c + 1'b1;
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // through the case/if tree can leave it unassigned and infer a latch.
      state_d     = state_q;
      vent_d      = vent_q;
      alarm_cnt_d = alarm_cnt_q;
      fan_d       = 1'b0;
      valve_d     = 1'b0;
      buzzer_d    = 1'b0;
      led_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (hi_conf)       state_d = ALARM;
            else if (mid_conf) state_d = WARN;
         end
         WARN: begin
            if (hi_conf)      state_d = ALARM;
            else if (lo_conf) state_d = IDLE;
         end
         ALARM: begin
            // ack is only honoured together with LO; it is never latched.
            if (ack && lo) state_d = VENT;
`ifdef GAS_CTRL_AUTOCLEAR_EN
            else if (lo_conf) state_d = VENT;
`endif
         end
         VENT: begin
            // Re-alarm wins over timer expiry on the same edge.
            if (hi_conf)             state_d = ALARM;
            else if (vent_q == 8'd0) state_d = IDLE;
            else                     vent_d  = vent_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase

      trans = (state_d != state_q);

      // Loading VENT_CYC-1 on entry and leaving at 0 gives exactly VENT_CYC
      // edges from the entry edge to the IDLE edge.
      if (trans && state_d == VENT) vent_d = 8'(VENT_CYC - 1);

      if (trans && state_d == ALARM && alarm_cnt_q != 8'hFF)
         alarm_cnt_d = alarm_cnt_q + 8'd1;

      hi_cnt_d  = (trans || !hi)  ? '0 : sat_inc(hi_cnt_q);
      mid_cnt_d = (trans || !mid) ? '0 : sat_inc(mid_cnt_q);
      lo_cnt_d  = (trans || !lo)  ? '0 : sat_inc(lo_cnt_q);

      // Actuators decode from the next state so they register on the same
      // edge as the state transition.
      unique case (state_d)
         IDLE:  ;
         WARN:  begin fan_d = 1'b1; led_d = 1'b1; end
         ALARM: begin fan_d = 1'b1; valve_d = 1'b1; buzzer_d = 1'b1; led_d = 1'b1; end
         VENT:  begin fan_d = 1'b1; valve_d = 1'b1; end
         default: ;
      endcase
   end

   // NOTE: all state registers, including the counters, are reset so an
   // arst_n pulse aborts any partial confirmation or ventilation count.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         hi_cnt_q    <= '0;
         mid_cnt_q   <= '0;
         lo_cnt_q    <= '0;
         vent_q      <= '0;
         alarm_cnt_q <= '0;
         fan_q       <= 1'b0;
         valve_q     <= 1'b0;
         buzzer_q    <= 1'b0;
         led_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q     <= state_d;
         hi_cnt_q    <= hi_cnt_d;
         mid_cnt_q   <= mid_cnt_d;
         lo_cnt_q    <= lo_cnt_d;
         vent_q      <= vent_d;
         alarm_cnt_q <= alarm_cnt_d;
         fan_q       <= fan_d;
         valve_q     <= valve_d;
         buzzer_q    <= buzzer_d;
         led_q       <= led_d;
      end
   end

   assign state       = state_q;
   assign alarm_cnt   = alarm_cnt_q;
   assign fan_on      = fan_q;
   assign valve_close = valve_q;
   assign buzzer      = buzzer_q;
   assign led_warn    = led_q;

endmodule
